// File: rtl/muldiv_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU engine with a private HI/LO pair.
// Signed operations run on magnitudes; the FIX cycle applies sign correction.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               a_neg_q, a_neg_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rshift, diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Sign flags are only meaningful for the signed ops (op[0] = 1).
  assign a_sgn = op[0] & a[WIDTH-1];
  assign b_sgn = op[0] & b[WIDTH-1];
  assign a_mag = a_sgn ? -a : a;
  assign b_mag = b_sgn ? -b : b;

  assign msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign rshift = {rem_q, acc_q[WIDTH-1]};
  assign diff   = rshift - {1'b0, mcand_q};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = a_neg_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    b_zero_d = b_zero_q;
    a_orig_d = a_orig_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          op_d     = op;
          neg_d    = a_sgn ^ b_sgn;
          a_neg_d  = a_sgn;
          b_zero_d = (b == '0);
          a_orig_d = a;
          rem_d    = '0;
          // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
          acc_d    = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
          mcand_d  = op[1] ? b_mag : a_mag;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end

      RUN: begin
        if (!op_q[1]) begin
          if (acc_q[0]) acc_d = {msum, acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end else begin
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            acc_d = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rshift[WIDTH-1:0];
            acc_d = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end

      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_zero_q) begin
          hi_d = a_orig_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      a_orig_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      b_zero_q <= b_zero_d;
      a_orig_q <= a_orig_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, random ops against a reference model,
// and hand-written sequences for busy-time writes, reset abort and back-to-back starts.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int n_ops = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic signed [31:0] q, r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    q = '0;
    r = '0;
    case (o)
      2'd0: return {32'h0, x} * {32'h0, y};
      2'd1: return sx * sy;
      2'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
    endcase
  endfunction

  // Scoreboard: every done pulse pops one expected {hi, lo}.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (hi=%h lo=%h)", hi, lo);
      end else begin
        chk("result", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // Driver: called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic do_op(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                       input logic [63:0] exp, input bit disturb, input bit with_we, input string name);
    logic [31:0] snap_hi, snap_lo;
    int cnt;
    bit stable;
    snap_hi = hi;
    snap_lo = lo;
    exp_q.push_back(exp);
    n_ops++;
    start = 1'b1;
    op = op_v;
    a = a_v;
    b = b_v;
    if (with_we) begin
      hi_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    a = $urandom;
    b = $urandom;
    cnt = 0;
    stable = 1'b1;
    while (busy && cnt < 100) begin
      cnt++;
      if (hi !== snap_hi || lo !== snap_lo) stable = 1'b0;
      if (disturb && cnt == 5) begin
        start = 1'b1;
        op = ~op_v;
        a = $urandom;
        b = $urandom;
        lo_we = 1'b1;
        wdata = 32'h0000_1234;
      end else begin
        start = 1'b0;
        lo_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    lo_we = 1'b0;
    chk($sformatf("%s_busy_cycles", name), 64'(cnt), 64'd33);
    chk($sformatf("%s_done_pulse", name), 64'(done), 64'd1);
    chk($sformatf("%s_hilo_stable", name), 64'(stable), 64'd1);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'd2, 32'd100,       32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[6] = '{2'd0, 32'd7,         32'd6,         32'h0000_0000, 32'd42};
    vecs[7] = '{2'd3, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
    vecs[8] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    rst_n = 1'b0;
    start = 1'b0;
    op = 2'd0;
    a = '0;
    b = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MTHI and MTLO together in IDLE
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("mthi", 64'(hi), 64'hA5A5_A5A5);
    chk("mtlo", 64'(lo), 64'hA5A5_A5A5);

    // Table vectors, issued back-to-back in each done cycle
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, 1'b0, 1'b0,
            $sformatf("vec%0d", i));

    // start together with hi_we: the write is dropped
    @(negedge clk);
    do_op(2'd0, 32'd3, 32'd4, {32'd0, 32'd12}, 1'b0, 1'b1, "start_with_mthi");

    // Second start and MTLO while busy are both ignored
    @(negedge clk);
    do_op(2'd2, 32'd1000, 32'd7, {32'd6, 32'd142}, 1'b1, 1'b0, "busy_disturb");

    // Random operations against the reference model
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (rop[0] && $urandom_range(0, 1) == 1) ra = -ra;
      do_op(rop, ra, rb, model(rop, ra, rb), 1'b0, 1'b0, $sformatf("rand%0d", i));
    end

    // Leave nonzero HI/LO so the reset clear is observable
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0, 1'b0, "pre_reset");

    // Reset mid-RUN aborts without a done pulse
    start = 1'b1;
    op = 2'd0;
    a = 32'd9;
    b = 32'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First start after release is accepted, then a back-to-back op
    do_op(2'd0, 32'd7, 32'd6, {32'd0, 32'd42}, 1'b0, 1'b0, "post_reset");
    do_op(2'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 1'b0, "back_to_back");

    repeat (40) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'(n_ops));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS core, sitting directly downstream of the register file read ports. It consumes the two operands read for rs/rt and executes MULT, MULTU, DIV and DIVU over 32 iterations into a private HI/LO register pair. MTHI/MTLO write HI/LO directly. HI/LO feed the MFHI/MFLO writeback path back into the register file.

## Interface
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.
- clk  in  1  single clock, all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin an operation; sampled only in IDLE.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  WIDTH  rs operand (multiplicand/dividend), taken from register file port A.
- b  in  WIDTH  rt operand (multiplier/divisor), taken from register file port B.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  operation in progress; pipeline stalls MFHI/MFLO/mul/div while high.
- done  out  1  one-cycle pulse when HI/LO take a new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 latches a, b and op.
  - For signed ops, |a| and |b| are latched together with the sign flags.
  - Iteration counter is cleared; next state RUN.
- RUN: one iteration per cycle. After iteration 32 (counter == WIDTH-1), next state FIX.
- Multiply (shift-add):
  - Uses a 2*WIDTH product accumulator.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the upper half.
  - Shift right by 1, keeping the carry into the MSB.
- Divide (restoring):
  - Uses a WIDTH+1 bit partial remainder.
  - Each cycle: shift the remainder left, bringing in the next dividend bit.
  - Trial-subtract the divisor. If the result is non-negative, keep it and shift quotient bit 1; otherwise restore and shift in 0.
- FIX:
  - Applies sign correction, writes hi/lo and pulses done. Next state IDLE.
  - MULT: the 64-bit product is negated if sign(a) != sign(b). hi = upper word, lo = lower word.
  - DIV: the quotient is negated if the signs differ; the remainder takes the sign of a.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (b == 0), both DIV and DIVU: lo = all ones, hi = a (original, unsigned bit pattern). No exception is raised; latency is unchanged.
- DIV overflow (a = 0x80000000, b = 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata to hi/lo on the next edge. Both may be asserted in the same cycle.
  - If start and hi_we/lo_we are asserted in the same IDLE cycle, start wins and the writes are dropped.
- Ignored while busy: start, hi_we and lo_we. The pending result overwrites hi/lo in FIX.
- All arithmetic is unsigned on magnitudes. No state is kept between operations except hi/lo.

## Timing
- Reset (async, immediate): state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators 0.
- Accept edge = edge N, where start=1 in IDLE.
- busy:
  - Goes to 1 after edge N.
  - Stays 1 through RUN (edges N+1..N+32) and FIX (edge N+33).
  - Returns to 0 after edge N+33.
- hi/lo update at edge N+33, and done=1 for exactly the cycle following N+33. Total latency is 33 edges.
- Back-to-back operations: start may be asserted in the cycle where done=1 (state IDLE). The next accept is therefore at edge N+34.
- hi/lo are stable and unchanged during RUN; intermediate values are never visible.
- Reset asserted mid-RUN or in FIX aborts the operation immediately with the reset values above. No done pulse is issued for the aborted operation.
- The first start after reset release is accepted normally on the first edge with rst_n=1.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - Check busy timing: 1 for 33 cycles.
  - done pulses once at edge N+33 with hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Repeat with DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide corner cases:
  - DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU a=0xFFFFFFFF, b=0x10 -> lo=0x0FFFFFFF, hi=0xF.
- While busy:
  - A second start with different operands is ignored, and the result matches the first operation.
  - lo_we=1 with wdata=0x1234 is dropped; after done, lo holds the divide result.
- In IDLE:
  - hi_we=1 and lo_we=1 with wdata=0xA5A5A5A5 -> both hi and lo read 0xA5A5A5A5 next cycle.
  - start together with hi_we -> hi_we is dropped and the operation runs.
- Reset and throughput:
  - rst_n low at cycle 10 of RUN -> busy=0, done=0, hi=lo=0 immediately, and no done pulse afterwards.
  - A new MULTU 7x6 after release -> lo=42, hi=0 at accept+33.
  - Back-to-back start in the done cycle is accepted.
